// File: rtl/aigc_demo_csr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aigc_demo_csr                                                |
// | Description : APB3 control/status register block with per-channel bus      |
// |               traffic sampling, saturating transfer counters and one-cycle |
// |               clear pulses.                                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aigc_demo_csr #(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] UNIT_ID_VAL = 32'hA1C0_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [11:0]           paddr,
  input  logic [31:0]           pwdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [31:0]           prdata,
  output logic [1:0]            ctrl0,
  output logic                  ctrl1,
  output logic [15:0]           ctrl2,
  output logic                  ctrl3,
  output logic [3:0]            m0_clr,
  output logic [3:0]            m1_clr,
  output logic                  m2_clear,
  output logic [31:0]           dummy_debug,
  input  logic [NUM_CH*8-1:0]   bus_pvld,
  input  logic [NUM_CH*8-1:0]   bus_prdy,
  input  logic [31:0]           status_in
);

  // Word offsets of the fixed registers (byte address >> 2)
  localparam logic [9:0] c_W_UNIT_ID = 10'h000;
  localparam logic [9:0] c_W_CTRL    = 10'h001;
  localparam logic [9:0] c_W_CFG0    = 10'h002;
  localparam logic [9:0] c_W_STATUS  = 10'h003;
  localparam logic [9:0] c_W_DUMMY   = 10'h004;
  localparam logic [9:0] c_W_CNT_CLR = 10'h005;
  // paddr[11:5] selecting the 32-byte windows of per-channel registers
  localparam logic [6:0] c_DBG_WIN   = 7'h01;   // 0x020..0x03F
  localparam logic [6:0] c_CNT_WIN   = 7'h03;   // 0x060..0x07F

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // Bus-side registers
  logic                r_pslverr;
  logic [31:0]         r_prdata;

  // Register file
  logic [1:0]          r_ctrl0;
  logic                r_ctrl1;
  logic [15:0]         r_ctrl2;
  logic                r_ctrl3;
  logic [31:0]         r_dummy;
  logic [3:0]          r_m0_clr;
  logic [3:0]          r_m1_clr;
  logic                r_m2_clear;

  // Sampled observation inputs
  logic [31:0]         r_status;
  logic [NUM_CH*8-1:0] r_pvld_q;
  logic [NUM_CH*8-1:0] r_prdy_q;

  // Per-channel counters
  logic [CNT_W-1:0]    r_cnt     [NUM_CH];
  logic [31:0]         w_cnt_ext [NUM_CH];
  logic [NUM_CH-1:0]   w_inc;
  logic [NUM_CH-1:0]   w_clr;

  // Decode / access qualification
  logic [9:0]          w_word;
  logic [2:0]          w_ch_idx;
  logic                w_ch_valid;
  logic                w_hit;
  logic                w_ro;
  logic                w_ok;
  logic                w_commit;
  logic                w_wr_commit;
  logic [31:0]         w_rdata;
  logic [31:0]         w_ctrl_word;
  logic                w_unused_addr_lsb;

  assign w_word            = paddr[11:2];
  assign w_ch_idx          = paddr[4:2];
  assign w_ch_valid        = ({29'd0, w_ch_idx} < 32'(NUM_CH));
  assign w_unused_addr_lsb = ^paddr[1:0];

  // The only edge on which an access takes effect: leaving WAIT with psel held
  assign w_commit    = (r_state == ST_WAIT) && psel;
  assign w_ok        = w_hit && !(pwrite && w_ro);
  assign w_wr_commit = w_commit && pwrite && w_ok;

  assign w_ctrl_word = {r_ctrl3, 7'd0, r_ctrl2, 5'd0, r_ctrl1, r_ctrl0};

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: one wait state between SETUP and ACCESS; losing psel aborts
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (psel && !penable) w_state_next = ST_SETUP;
      ST_SETUP:  w_state_next = psel ? ST_WAIT : ST_IDLE;
      ST_WAIT:   w_state_next = psel ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Address decode and read multiplexer
  always_comb begin
    w_hit   = 1'b0;
    w_ro    = 1'b0;
    w_rdata = 32'd0;
    case (w_word)
      c_W_UNIT_ID: begin
        w_hit   = 1'b1;
        w_ro    = 1'b1;
        w_rdata = UNIT_ID_VAL;
      end
      c_W_CTRL: begin
        w_hit   = 1'b1;
        w_rdata = w_ctrl_word;
      end
      c_W_CFG0: begin
        w_hit   = 1'b1;
      end
      c_W_STATUS: begin
        w_hit   = 1'b1;
        w_ro    = 1'b1;
        w_rdata = r_status;
      end
      c_W_DUMMY: begin
        w_hit   = 1'b1;
        w_rdata = r_dummy;
      end
      c_W_CNT_CLR: begin
        w_hit   = 1'b1;
      end
      default: begin
        if ((paddr[11:5] == c_DBG_WIN) && w_ch_valid) begin
          w_hit = 1'b1;
          w_ro  = 1'b1;
          for (int k = 0; k < NUM_CH; k++) begin
            if (w_ch_idx == k[2:0]) begin
              w_rdata = {8'd0,
                         r_pvld_q[8*k +: 8] & r_prdy_q[8*k +: 8],
                         r_prdy_q[8*k +: 8],
                         r_pvld_q[8*k +: 8]};
            end
          end
        end else if ((paddr[11:5] == c_CNT_WIN) && w_ch_valid) begin
          w_hit = 1'b1;
          w_ro  = 1'b1;
          for (int k = 0; k < NUM_CH; k++) begin
            if (w_ch_idx == k[2:0]) begin
              w_rdata = w_cnt_ext[k];
            end
          end
        end
      end
    endcase
  end

  // Completion response: captured on the commit edge, zero in every other cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prdata  <= 32'd0;
      r_pslverr <= 1'b0;
    end else begin
      r_prdata  <= (w_commit && w_ok && !pwrite) ? w_rdata : 32'd0;
      r_pslverr <= w_commit && !w_ok;
    end
  end

  // Writable registers and the CFG0 pulses, which last only the ACCESS cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl0    <= 2'd0;
      r_ctrl1    <= 1'b0;
      r_ctrl2    <= 16'd0;
      r_ctrl3    <= 1'b0;
      r_dummy    <= 32'd0;
      r_m0_clr   <= 4'd0;
      r_m1_clr   <= 4'd0;
      r_m2_clear <= 1'b0;
    end else begin
      r_m0_clr   <= 4'd0;
      r_m1_clr   <= 4'd0;
      r_m2_clear <= 1'b0;
      if (w_wr_commit) begin
        case (w_word)
          c_W_CTRL: begin
            r_ctrl0 <= pwdata[1:0];
            r_ctrl1 <= pwdata[2];
            r_ctrl2 <= pwdata[23:8];
            r_ctrl3 <= pwdata[31];
          end
          c_W_CFG0: begin
            r_m0_clr   <= pwdata[3:0];
            r_m1_clr   <= pwdata[7:4];
            r_m2_clear <= pwdata[24];
          end
          c_W_DUMMY: begin
            r_dummy <= pwdata;
          end
          default: ;
        endcase
      end
    end
  end

  // Observation samples: status word and raw channel handshakes, one cycle late
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status <= 32'd0;
      r_pvld_q <= '0;
      r_prdy_q <= '0;
    end else begin
      r_status <= status_in;
      r_pvld_q <= bus_pvld;
      r_prdy_q <= bus_prdy;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_inc[k]     = |(bus_pvld[8*k +: 8] & bus_prdy[8*k +: 8]);
    assign w_clr[k]     = w_wr_commit && (w_word == c_W_CNT_CLR) && pwdata[k];
    assign w_cnt_ext[k] = 32'(r_cnt[k]);

    // Saturating transfer counter; a clear on the commit edge wins over a count
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt[k] <= '0;
      end else if (w_clr[k]) begin
        r_cnt[k] <= '0;
      end else if (w_inc[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
        r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  assign pready      = (r_state == ST_ACCESS);
  assign pslverr     = r_pslverr;
  assign prdata      = r_prdata;
  assign ctrl0       = r_ctrl0;
  assign ctrl1       = r_ctrl1;
  assign ctrl2       = r_ctrl2;
  assign ctrl3       = r_ctrl3;
  assign m0_clr      = r_m0_clr;
  assign m1_clr      = r_m1_clr;
  assign m2_clear    = r_m2_clear;
  assign dummy_debug = r_dummy;

endmodule
`default_nettype wire

// File: tb/tb_aigc_demo_csr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aigc_demo_csr                                             |
// | Description : Scoreboard bench for aigc_demo_csr with an abstract register |
// |               model, randomized APB traffic and channel activity.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_aigc_demo_csr;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 8;
  localparam int BW      = NUM_CH * 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] UNIT_ID = 32'hA1C0_0001;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            psel, penable, pwrite;
  logic [11:0]     paddr;
  logic [31:0]     pwdata;
  logic            pready, pslverr;
  logic [31:0]     prdata;
  logic [1:0]      ctrl0;
  logic            ctrl1;
  logic [15:0]     ctrl2;
  logic            ctrl3;
  logic [3:0]      m0_clr, m1_clr;
  logic            m2_clear;
  logic [31:0]     dummy_debug;
  logic [BW-1:0]   bus_pvld, bus_prdy;
  logic [31:0]     status_in;

  aigc_demo_csr #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .UNIT_ID_VAL(UNIT_ID)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .prdata     (prdata),
    .ctrl0      (ctrl0),
    .ctrl1      (ctrl1),
    .ctrl2      (ctrl2),
    .ctrl3      (ctrl3),
    .m0_clr     (m0_clr),
    .m1_clr     (m1_clr),
    .m2_clear   (m2_clear),
    .dummy_debug(dummy_debug),
    .bus_pvld   (bus_pvld),
    .bus_prdy   (bus_prdy),
    .status_in  (status_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  m0;
    logic [3:0]  m1;
    logic        m2;
    logic [31:0] ctrl;
    logic [31:0] dd;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state (what a software view of the block should show)
  logic [31:0]   m_ctrl;
  logic [31:0]   m_dd;
  logic [31:0]   m_status;
  logic [BW-1:0] m_pv, m_pr;
  int            m_cnt [NUM_CH];
  logic          commit_now = 1'b0;
  int            traffic_mode = 2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [11:0] align(input logic [11:0] a);
    return {a[11:2], 2'b00};
  endfunction

  // Is the address a register the bus may reach, and is it writable
  function automatic bit is_mapped(input logic [11:0] a);
    logic [11:0] aa = align(a);
    if (aa <= 12'h014) return 1'b1;
    if (aa >= 12'h020 && aa < 12'(32'h020 + 4 * NUM_CH)) return 1'b1;
    if (aa >= 12'h060 && aa < 12'(32'h060 + 4 * NUM_CH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_rw(input logic [11:0] a);
    logic [11:0] aa = align(a);
    return (aa == 12'h004) || (aa == 12'h008) || (aa == 12'h010) || (aa == 12'h014);
  endfunction

  function automatic bit acc_ok(input logic [11:0] a, input logic w);
    return is_mapped(a) && (!w || is_rw(a));
  endfunction

  function automatic logic [31:0] read_val(input logic [11:0] a);
    logic [11:0] aa = align(a);
    int k;
    if (aa == 12'h000) return UNIT_ID;
    if (aa == 12'h004) return m_ctrl;
    if (aa == 12'h00C) return m_status;
    if (aa == 12'h010) return m_dd;
    if (aa >= 12'h020 && aa < 12'h040) begin
      k = (int'(aa) - 32'h20) / 4;
      return {8'd0, m_pv[8*k +: 8] & m_pr[8*k +: 8], m_pr[8*k +: 8], m_pv[8*k +: 8]};
    end
    if (aa >= 12'h060 && aa < 12'h080) begin
      k = (int'(aa) - 32'h60) / 4;
      return 32'(m_cnt[k]);
    end
    return 32'd0;
  endfunction

  function automatic exp_t predict(input logic [11:0] a, input logic w, input logic [31:0] d);
    exp_t e;
    bit   ok = acc_ok(a, w);
    e.err   = !ok;
    e.rdata = (ok && !w) ? read_val(a) : 32'd0;
    e.m0    = 4'd0;
    e.m1    = 4'd0;
    e.m2    = 1'b0;
    e.ctrl  = m_ctrl;
    e.dd    = m_dd;
    if (ok && w) begin
      case (align(a))
        12'h004: e.ctrl = d & 32'h80FF_FF07;
        12'h008: begin e.m0 = d[3:0]; e.m1 = d[7:4]; e.m2 = d[24]; end
        12'h010: e.dd = d;
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic bit is_clr(input int k);
    return commit_now && pwrite && (align(paddr) == 12'h014) && pwdata[k];
  endfunction

  function automatic bit traffic(input int k);
    return ((bus_pvld[8*k +: 8] & bus_prdy[8*k +: 8]) != 8'd0);
  endfunction

  // Reference model: advances once per clock, predicts each committed access
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ctrl   <= 32'd0;
      m_dd     <= 32'd0;
      m_status <= 32'd0;
      m_pv     <= '0;
      m_pr     <= '0;
      for (int k = 0; k < NUM_CH; k++) m_cnt[k] <= 0;
    end else begin
      m_status <= status_in;
      m_pv     <= bus_pvld;
      m_pr     <= bus_prdy;
      for (int k = 0; k < NUM_CH; k++) begin
        if (is_clr(k)) m_cnt[k] <= 0;
        else if (traffic(k) && m_cnt[k] < CNT_MAX) m_cnt[k] <= m_cnt[k] + 1;
      end
      if (commit_now) begin
        sb.push_back(predict(paddr, pwrite, pwdata));
        if (pwrite && acc_ok(paddr, 1'b1)) begin
          if (align(paddr) == 12'h004) m_ctrl <= pwdata & 32'h80FF_FF07;
          if (align(paddr) == 12'h010) m_dd <= pwdata;
        end
      end
    end
  end

  // Monitor: compares every completion against the scoreboard; idle cycles must be quiet
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (pready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("prdata",      prdata,           e.rdata);
          chk("pslverr",     32'(pslverr),     32'(e.err));
          chk("m0_clr",      32'(m0_clr),      32'(e.m0));
          chk("m1_clr",      32'(m1_clr),      32'(e.m1));
          chk("m2_clear",    32'(m2_clear),    32'(e.m2));
          chk("ctrl_fields", {ctrl3, 7'd0, ctrl2, 5'd0, ctrl1, ctrl0}, e.ctrl);
          chk("dummy_debug", dummy_debug,      e.dd);
        end
      end else begin
        chk("idle_prdata",  prdata, 32'd0);
        chk("idle_outputs", {23'd0, pslverr, m0_clr, m1_clr, m2_clear}, 32'd0);
      end
    end
  end

  // Channel activity and status word stimulus
  always @(negedge clk) begin
    status_in <= $urandom;
    case (traffic_mode)
      0: begin
        bus_pvld <= BW'($urandom);
        bus_prdy <= ($urandom_range(0, 3) == 0) ? BW'($urandom) : '0;
      end
      1: begin
        bus_pvld <= BW'(8'h01);
        bus_prdy <= BW'(8'h01);
      end
      default: begin
        bus_pvld <= '0;
        bus_prdy <= '0;
      end
    endcase
  end

  task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(negedge clk);                 // SETUP
    penable = 1'b1;
    @(negedge clk);                 // WAIT: next edge commits
    commit_now = 1'b1;
    @(negedge clk);                 // ACCESS
    commit_now = 1'b0;
    chk("pready_latency", 32'(pready), 32'd1);
  endtask

  task automatic apb_drop(input logic [11:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);                 // WAIT: drop psel before commit
    psel = 1'b0; penable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic apb_rst(input logic [11:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);                 // WAIT: reset hits the commit edge
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  logic [11:0] addr_pool [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_pool = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018,
                  12'h020, 12'h024, 12'h028, 12'h060, 12'h064, 12'h068, 12'h7FC};
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'd0; pwdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_prdata",  prdata, 32'd0);
    chk("rst_pready",  32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_ctrl",    {ctrl3, 7'd0, ctrl2, 5'd0, ctrl1, ctrl0}, 32'd0);
    chk("rst_dummy",   dummy_debug, 32'd0);
    chk("rst_pulses",  {23'd0, m0_clr, m1_clr, m2_clear}, 32'd0);
    rst_n = 1'b1;

    apb(12'h000, 1'b0, 32'd0);
    chk("unit_id_literal", prdata, 32'hA1C0_0001);
    apb(12'h004, 1'b1, 32'hFFFF_FFFF);
    apb(12'h004, 1'b0, 32'd0);
    chk("ctrl_read_literal", prdata, 32'h80FF_FF07);
    apb(12'h008, 1'b1, 32'h0100_00A5);
    apb(12'h008, 1'b0, 32'd0);
    apb(12'h010, 1'b1, 32'hDEAD_BEEF);
    apb(12'h010, 1'b0, 32'd0);

    traffic_mode = 1;
    repeat (300) @(negedge clk);
    apb(12'h060, 1'b0, 32'd0);
    chk("cnt0_saturated", prdata, 32'd255);
    apb(12'h014, 1'b1, 32'h0000_0001);
    apb(12'h060, 1'b0, 32'd0);
    apb(12'h020, 1'b0, 32'd0);
    traffic_mode = 2;

    apb(12'h068, 1'b0, 32'd0);
    apb(12'h000, 1'b1, 32'h1234_5678);
    apb(12'h7FC, 1'b0, 32'd0);
    apb(12'h000, 1'b0, 32'd0);
    apb(12'h00E, 1'b0, 32'd0);

    apb_drop(12'h004, 1'b1, 32'h0000_0001);
    apb(12'h004, 1'b0, 32'd0);
    apb_rst(12'h004, 1'b1, 32'h0000_0003);
    chk("ctrl0_after_abort", 32'(ctrl0), 32'd0);
    apb(12'h004, 1'b0, 32'd0);

    traffic_mode = 0;
    for (int i = 0; i < 200; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      if ($urandom_range(0, 9) == 0) a = 12'($urandom);
      else a = addr_pool[$urandom_range(0, 13)] | 12'($urandom_range(0, 3));
      d = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      apb(a, 1'($urandom_range(0, 1)), d);
    end
    traffic_mode = 2;

    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
